// File: rtl/cic_decim_var.sv
// cic_decim_var: variable-rate (1..255) N-stage CIC decimator with full-precision output.
// Build option CIC_DECIM_VAR_RATE_FLUSH_EN: flush state on rate change and mute the first N outputs.
module cic_decim_var #(
  parameter int WIDTH_IN  = 16,
  parameter int N         = 4,
  parameter int RATE_BITS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [RATE_BITS-1:0]            rate,
  input  logic                            strobe_in,
  input  logic [WIDTH_IN-1:0]             signal_in,
  output logic                            strobe_out,
  output logic [WIDTH_IN+N*RATE_BITS-1:0] signal_out
);

  localparam int WIDTH_OUT = WIDTH_IN + N * RATE_BITS;
  localparam int SUPP_BITS = $clog2(N + 1);

  logic [WIDTH_OUT-1:0] integ_q [N];
  logic [WIDTH_OUT-1:0] integ_d [N];
  logic [WIDTH_OUT-1:0] dly_q   [N];
  logic [WIDTH_OUT-1:0] dly_d   [N];
  logic [WIDTH_OUT-1:0] samp_q, samp_d;
  logic [WIDTH_OUT-1:0] signal_out_q, signal_out_d;
  logic [RATE_BITS-1:0] count_q, count_d;
  logic                 comb_go_q, comb_go_d;
  logic                 emit_q, emit_d;
  logic                 strobe_out_q, strobe_out_d;

  logic [RATE_BITS-1:0] eff_rate;
  logic [WIDTH_OUT-1:0] in_ext;
  logic [WIDTH_OUT-1:0] comb_acc;
  logic                 accept;
  logic                 dec_evt;
  logic                 flush;
  logic                 emit_ok;

  assign accept   = strobe_in & enable;
  assign eff_rate = (rate == '0) ? RATE_BITS'(1) : rate;
  assign dec_evt  = accept && (count_q == '0);
  assign in_ext   = {{(WIDTH_OUT - WIDTH_IN){signal_in[WIDTH_IN-1]}}, signal_in};

`ifdef CIC_DECIM_VAR_RATE_FLUSH_EN
  logic [RATE_BITS-1:0] rate_prev_q, rate_prev_d;
  logic [SUPP_BITS-1:0] supp_q, supp_d;

  // A flushing event restarts the filter and counts as the first muted event.
  assign flush   = dec_evt && (eff_rate != rate_prev_q);
  assign emit_ok = (supp_q == '0) && !flush;

  always_comb begin
    rate_prev_d = rate_prev_q;
    supp_d      = supp_q;
    if (dec_evt) begin
      rate_prev_d = eff_rate;
      if (flush) begin
        supp_d = SUPP_BITS'(N - 1);
      end else if (supp_q != '0) begin
        supp_d = supp_q - SUPP_BITS'(1);
      end
    end
    if (!enable) begin
      rate_prev_d = '0;
      supp_d      = SUPP_BITS'(N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_prev_q <= '0;
      supp_q      <= SUPP_BITS'(N);
    end else begin
      rate_prev_q <= rate_prev_d;
      supp_q      <= supp_d;
    end
  end
`else
  assign flush   = 1'b0;
  assign emit_ok = 1'b1;
`endif

  // NOTE: every _d gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    for (int k = 0; k < N; k++) begin
      integ_d[k] = integ_q[k];
    end
    count_d   = count_q;
    samp_d    = samp_q;
    comb_go_d = dec_evt;
    emit_d    = dec_evt & emit_ok;

    // Each stage adds the pre-update value of its predecessor; sums wrap modulo 2^WIDTH_OUT.
    if (accept) begin
      integ_d[0] = (flush ? '0 : integ_q[0]) + in_ext;
      for (int k = 1; k < N; k++) begin
        integ_d[k] = (flush ? '0 : integ_q[k]) + (flush ? '0 : integ_q[k-1]);
      end
      count_d = (count_q == '0) ? eff_rate - RATE_BITS'(1) : count_q - RATE_BITS'(1);
    end

    if (dec_evt) begin
      samp_d = flush ? '0 : integ_q[N-1];
    end

    // NOTE: comb_acc is a blocking scratch value reused down the cascade within this one evaluation.
    comb_acc = samp_q;
    for (int k = 0; k < N; k++) begin
      dly_d[k] = comb_go_q ? comb_acc : dly_q[k];
      comb_acc = comb_acc - dly_q[k];
    end
    if (flush) begin
      for (int k = 0; k < N; k++) begin
        dly_d[k] = '0;
      end
    end

    strobe_out_d = comb_go_q & emit_q;
    signal_out_d = (comb_go_q & emit_q) ? comb_acc : signal_out_q;

    if (!enable) begin
      for (int k = 0; k < N; k++) begin
        integ_d[k] = '0;
        dly_d[k]   = '0;
      end
      count_d      = '0;
      samp_d       = '0;
      comb_go_d    = 1'b0;
      emit_d       = 1'b0;
      strobe_out_d = 1'b0;
      signal_out_d = '0;
    end
  end

  // NOTE: the integrator/comb arrays are plain flops, so they are cleared by reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= '0;
        dly_q[k]   <= '0;
      end
      count_q      <= '0;
      samp_q       <= '0;
      comb_go_q    <= 1'b0;
      emit_q       <= 1'b0;
      strobe_out_q <= 1'b0;
      signal_out_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      for (int k = 0; k < N; k++) begin
        integ_q[k] <= integ_d[k];
        dly_q[k]   <= dly_d[k];
      end
      count_q      <= count_d;
      samp_q       <= samp_d;
      comb_go_q    <= comb_go_d;
      emit_q       <= emit_d;
      strobe_out_q <= strobe_out_d;
      signal_out_q <= signal_out_d;
    end
  end

  assign strobe_out = strobe_out_q;
  assign signal_out = signal_out_q;

endmodule
